// File: rtl/core_pkg.sv
// Shared core definitions: redirect target encodings, PC generator FSM states,
// and the default sequential fetch increment.
package core_pkg;

  localparam int unsigned SEL_W              = 3;
  localparam int unsigned DEFAULT_INST_BYTES = 4;

  // Redirect target mode carried on redir_sel.
  typedef enum logic [SEL_W-1:0] {
    SEL_ALU_OUT  = 3'd0,
    SEL_MEM_OUT  = 3'd1,
    SEL_NEXT_PC  = 3'd2,
    SEL_IMM_PC   = 3'd3,
    SEL_IMM_ONLY = 3'd4
  } redir_sel_e;

  // PC generator control states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational redirect target mux/adder.
// Ports:
//   sel      - target mode (core_pkg::redir_sel_e encoding, 5..7 act as NEXT_PC)
//   base     - PC of the redirecting instruction
//   alu_out  - ALU result
//   mem_out  - load data (indirect target)
//   ext_imm  - sign-extended immediate
//   target_c - selected target address (sums wrap modulo 2^XLEN)
module pc_target_sel
  import core_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INST_BYTES = DEFAULT_INST_BYTES
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [XLEN-1:0]  base,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [XLEN-1:0]  mem_out,
  input  logic [XLEN-1:0]  ext_imm,
  output logic [XLEN-1:0]  target_c
);

  // Unused encodings fall back to the sequential successor of base.
  always_comb begin
    target_c = base + XLEN'(INST_BYTES);
    case (redir_sel_e'(sel))
      SEL_ALU_OUT:  target_c = alu_out;
      SEL_MEM_OUT:  target_c = mem_out;
      SEL_NEXT_PC:  target_c = base + XLEN'(INST_BYTES);
      SEL_IMM_PC:   target_c = base + ext_imm;
      SEL_IMM_ONLY: target_c = ext_imm;
      default:      target_c = base + XLEN'(INST_BYTES);
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch PC, offers it to imem over a
// valid/ready handshake and applies EX redirects. A redirect arriving while the
// offered PC is stalled is parked in pend_pc and the stale fetch is flagged.
// Optional feature macro: PC_ALIGN_CHK_EN (force targets word-aligned and
// pulse misalign when a target had nonzero low bits).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   pc, pc_valid, pc_ready   - fetch address handshake to imem
//   wrong_path               - accepted fetch is stale (high throughout PEND)
//   redir_valid, redir_sel   - redirect request and target mode
//   redir_base, alu_out,
//   mem_out, ext_imm         - target operands
//   misalign                 - one-cycle pulse after a misaligned target write
module pc_gen
  import core_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter int unsigned INST_BYTES = DEFAULT_INST_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  input  logic             pc_ready,
  output logic             wrong_path,
  input  logic             redir_valid,
  input  logic [SEL_W-1:0] redir_sel,
  input  logic [XLEN-1:0]  redir_base,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [XLEN-1:0]  mem_out,
  input  logic [XLEN-1:0]  ext_imm,
  output logic             misalign
);

  localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VEC);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic [XLEN-1:0] raw_target_c;
  logic [XLEN-1:0] target_c;
  logic            tgt_write_c;

  pc_target_sel #(
    .XLEN      (XLEN),
    .INST_BYTES(INST_BYTES)
  ) u_target_sel (
    .sel     (redir_sel),
    .base    (redir_base),
    .alu_out (alu_out),
    .mem_out (mem_out),
    .ext_imm (ext_imm),
    .target_c(raw_target_c)
  );

`ifdef PC_ALIGN_CHK_EN
  logic misalign_q, misalign_d;

  assign target_c = {raw_target_c[XLEN-1:2], 2'b00};

  // Pulse when a freshly selected target lands in pc or pend_pc unaligned.
  always_comb begin
    misalign_d = tgt_write_c && (raw_target_c[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign target_c = raw_target_c;
  assign misalign = 1'b0;
`endif

  // Next-state, next-PC and pending-target logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    tgt_write_c = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (redir_valid) begin
          pc_d        = target_c;
          tgt_write_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (redir_valid) begin
          tgt_write_c = 1'b1;
          if (pc_ready) begin
            pc_d = target_c;
          end else begin
            // Offered pc must stay stable until accepted; park the target.
            pend_pc_d = target_c;
            state_d   = ST_PEND;
          end
        end else if (pc_ready) begin
          pc_d = pc_q + XLEN'(INST_BYTES);
        end
      end
      ST_PEND: begin
        if (redir_valid) tgt_write_c = 1'b1;
        if (pc_ready) begin
          pc_d    = redir_valid ? target_c : pend_pc_q;
          state_d = ST_RUN;
        end else if (redir_valid) begin
          pend_pc_d = target_c;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    pc_valid_d = (state_d != ST_BOOT);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign pc         = pc_q;
  assign pc_valid   = pc_valid_q;
  assign wrong_path = (state_q == ST_PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (XLEN=32, RESET_VEC=0, INST_BYTES=4).
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        wrong_path;
  logic        redir_valid;
  logic [2:0]  redir_sel;
  logic [31:0] redir_base;
  logic [31:0] alu_out;
  logic [31:0] mem_out;
  logic [31:0] ext_imm;
  logic        misalign;

  int errors = 0;
  int checks = 0;

`ifdef PC_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0000),
    .INST_BYTES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .wrong_path (wrong_path),
    .redir_valid(redir_valid),
    .redir_sel  (redir_sel),
    .redir_base (redir_base),
    .alu_out    (alu_out),
    .mem_out    (mem_out),
    .ext_imm    (ext_imm),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic redir(input logic [2:0] sel, input logic [31:0] base,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] imm);
    redir_valid = 1'b1;
    redir_sel   = sel;
    redir_base  = base;
    alu_out     = alu;
    mem_out     = mem;
    ext_imm     = imm;
  endtask

  initial begin
    rst = 1'b1; pc_ready = 1'b0; redir_valid = 1'b0; redir_sel = 3'd0;
    redir_base = '0; alu_out = '0; mem_out = '0; ext_imm = '0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(pc_valid), 32'd0);
    chk("rst_wp", 32'(wrong_path), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);

    // Boot and sequential fetch with pc_ready held high.
    rst = 1'b0; pc_ready = 1'b1;
    #1 chk("boot_valid", 32'(pc_valid), 32'd0);
    step();
    chk("run_valid", 32'(pc_valid), 32'd1);
    chk("seq0", pc, 32'h0);
    step(); chk("seq1", pc, 32'h4);
    step(); chk("seq2", pc, 32'h8);

    // Immediate redirects with ready high.
    redir(3'd4, 32'h0, 32'h0, 32'h0, 32'h100);
    step(); chk("imm_only", pc, 32'h100);
    redir(3'd3, 32'h0F0, 32'h0, 32'h0, 32'hFFFF_FFF0);
    step(); chk("imm_pc", pc, 32'h0E0);
    chk("imm_pc_wp", 32'(wrong_path), 32'd0);

    // Redirect while stalled: pc holds, wrong_path until handshake.
    redir(3'd4, 32'h0, 32'h0, 32'h0, 32'h200);
    step(); chk("to_200", pc, 32'h200);
    pc_ready = 1'b0;
    redir(3'd0, 32'h0, 32'h400, 32'h0, 32'h0);
    step(); chk("pend_pc0", pc, 32'h200);
    chk("pend_wp0", 32'(wrong_path), 32'd1);
    chk("pend_valid", 32'(pc_valid), 32'd1);
    redir_valid = 1'b0;
    step(); chk("pend_pc1", pc, 32'h200);
    chk("pend_wp1", 32'(wrong_path), 32'd1);
    pc_ready = 1'b1;
    step(); chk("pend_apply", pc, 32'h400);
    chk("pend_wp_clr", 32'(wrong_path), 32'd0);

    // Newest pending redirect wins.
    pc_ready = 1'b0;
    redir(3'd0, 32'h0, 32'h400, 32'h0, 32'h0);
    step();
    redir(3'd4, 32'h0, 32'h0, 32'h0, 32'h800);
    step(); chk("pend2_hold", pc, 32'h400);
    redir_valid = 1'b0; pc_ready = 1'b1;
    step(); chk("pend2_apply", pc, 32'h800);

    // Redirect on the same cycle as the pending handshake.
    pc_ready = 1'b0;
    redir(3'd0, 32'h0, 32'h500, 32'h0, 32'h0);
    step();
    pc_ready = 1'b1;
    redir(3'd1, 32'h0, 32'h0, 32'h600, 32'h0);
    step(); chk("pend_same", pc, 32'h600);

    // NEXT_PC and fallback encodings, including wrap.
    redir(3'd6, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    step(); chk("sel6_wrap", pc, 32'h0);
    redir(3'd2, 32'h30, 32'h0, 32'h0, 32'h0);
    step(); chk("sel2", pc, 32'h34);
    redir(3'd7, 32'h10, 32'h0, 32'h0, 32'h0);
    step(); chk("sel7", pc, 32'h14);
    redir_valid = 1'b0;
    step(); chk("seq_after", pc, 32'h18);
    pc_ready = 1'b0;
    step(); chk("hold", pc, 32'h18);
    chk("hold_wp", 32'(wrong_path), 32'd0);

    // Misaligned targets.
    pc_ready = 1'b1;
    redir(3'd0, 32'h0, 32'h1003, 32'h0, 32'h0);
    step(); chk("mis_pc", pc, ALIGN ? 32'h1000 : 32'h1003);
    chk("mis_pulse", 32'(misalign), ALIGN ? 32'd1 : 32'd0);
    redir_valid = 1'b0; pc_ready = 1'b0;
    step(); chk("mis_clr", 32'(misalign), 32'd0);
    redir(3'd0, 32'h0, 32'h2002, 32'h0, 32'h0);
    step(); chk("mis_pend_pulse", 32'(misalign), ALIGN ? 32'd1 : 32'd0);
    redir_valid = 1'b0; pc_ready = 1'b1;
    step(); chk("mis_pend_pc", pc, ALIGN ? 32'h2000 : 32'h2002);
    chk("mis_pend_clr", 32'(misalign), 32'd0);

    // Reset in PEND discards the pending target.
    pc_ready = 1'b0;
    redir(3'd0, 32'h0, 32'h3000, 32'h0, 32'h0);
    step();
    rst = 1'b1; redir_valid = 1'b0;
    step(); chk("rstp_pc", pc, 32'h0);
    chk("rstp_valid", 32'(pc_valid), 32'd0);
    chk("rstp_wp", 32'(wrong_path), 32'd0);
    rst = 1'b0; pc_ready = 1'b1;
    step(); chk("rstp_run_pc", pc, 32'h0);
    chk("rstp_run_valid", 32'(pc_valid), 32'd1);
    step(); chk("rstp_seq", pc, 32'h4);

    // Redirect taken during BOOT.
    rst = 1'b1;
    step();
    rst = 1'b0;
    redir(3'd4, 32'h0, 32'h0, 32'h0, 32'h44);
    step(); chk("boot_redir_pc", pc, 32'h44);
    chk("boot_redir_valid", 32'(pc_valid), 32'd1);
    redir_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
